// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the 8-bit peripheral bus: FSM state
//                encodings, default geometry and timeout constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // Bus initiator FSM encodings (2-bit, shared with peripheral blocks)
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_strobe = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    // Default bus address width and WAIT-cycle timeout
    localparam int c_default_size_addr = 8;
    localparam int c_default_timeout   = 15;

    // Counter width able to hold every value 0..t
    function automatic int f_timer_width(input int t);
        return $clog2(t + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer
//  Description : WAIT-cycle counter for the bus initiator. Cleared while the
//                master is in STROBE, counts each enabled cycle, and flags
//                the TIMEOUT-th enabled cycle as expired.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timer
    import bus_pkg::*;
#(
    parameter int TIMEOUT = c_default_timeout
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               c_width = f_timer_width(TIMEOUT);
    localparam logic [c_width-1:0] c_last  = c_width'(TIMEOUT - 1);

    logic [c_width-1:0] r_count;

    // The current enabled cycle is the last one allowed when the count hits TIMEOUT-1
    assign o_expired = i_enable && (r_count == c_last);

    // Count enabled cycles; stop at the limit so the value never wraps
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : bus_master
//  Description : Single-outstanding initiator for the 8-bit peripheral bus.
//                Accepts one core request, issues a one-cycle read/write
//                strobe, waits for the matching peripheral ready and returns
//                a one-cycle response.
//                Optional feature macro: BUS_MASTER_TIMEOUT_EN - aborts a
//                transaction with resp_err after TIMEOUT unanswered WAIT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_master
    import bus_pkg::*;
#(
    parameter int SIZE_ADDR = c_default_size_addr,
    parameter int TIMEOUT   = c_default_timeout
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [SIZE_ADDR-1:0] req_addr,
    input  logic [7:0]           req_wdata,
    output logic                 resp_valid,
    output logic [7:0]           resp_rdata,
    output logic                 resp_err,
    output logic                 bus_read,
    output logic                 bus_write,
    output logic [SIZE_ADDR-1:0] bus_address,
    output logic [7:0]           bus_data_out,
    input  logic [7:0]           bus_data_in,
    input  logic                 bus_ready_r,
    input  logic                 bus_ready_w
);

    // A zero timeout would make every transaction fail before it could answer
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("bus_master: TIMEOUT must be >= 1");
    end

    logic [1:0] r_state;
    logic       r_write;
    logic       w_ready_match;
    logic       w_timed_out;
    logic       w_done;

    // Only the ready matching the latched direction can complete a transfer
    assign w_ready_match = r_write ? bus_ready_w : bus_ready_r;
    assign w_done        = (r_state == c_st_wait) && (w_ready_match || w_timed_out);
    assign req_ready     = (r_state == c_st_idle);

`ifdef BUS_MASTER_TIMEOUT_EN
    logic r_err;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == c_st_strobe),
        .i_enable  (r_state == c_st_wait),
        .o_expired (w_timed_out)
    );

    // Error flag: set only when the wait ends without a matching ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_done) begin
            r_err <= !w_ready_match;
        end
    end

    assign resp_err = r_err;
`else
    assign w_timed_out = 1'b0;
    assign resp_err    = 1'b0;
`endif

    // Transaction sequencer: IDLE -> STROBE -> WAIT -> RESP -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_write      <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 8'h00;
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            bus_address  <= '0;
            bus_data_out <= 8'h00;
        end else begin
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            resp_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_write      <= req_write;
                        bus_address  <= req_addr;
                        bus_data_out <= req_wdata;
                        bus_read     <= !req_write;
                        bus_write    <= req_write;
                        r_state      <= c_st_strobe;
                    end
                end
                c_st_strobe: begin
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (w_done) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= (w_ready_match && !r_write) ? bus_data_in : 8'h00;
                        r_state    <= c_st_resp;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
